// File: rtl/ex_div_unit_pkg.sv
// Shared types and constants for the EX-stage radix-2 restoring divider.
package ex_div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_DONE
    } div_state_t;

    typedef enum logic [2:0] {
        F3_DIV  = 3'b100,
        F3_DIVU = 3'b101,
        F3_REM  = 3'b110,
        F3_REMU = 3'b111
    } mult_funct3_t;

    localparam logic [31:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV_INT_MIN  = 32'h8000_0000;

    function automatic logic is_signed_op(input logic [2:0] f3);
        return (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/ex_div_unit_div_step.sv
// One combinational restoring-division iteration.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] div_mag,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] sh;
    logic             ge;

    assign sh = {rem_in, quo_in[WIDTH-1]};
    assign ge = sh >= {2'b00, div_mag};

    always_comb begin
        rem_out = sh[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], 1'b0};
        if (ge) begin
            rem_out = sh[WIDTH:0] - {1'b0, div_mag};
            quo_out = {quo_in[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/ex_div_unit.sv
// Multi-cycle RV32M divider: magnitude division followed by a sign-fix step.
module ex_div_unit
    import ex_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

    div_state_t       state_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dmag_q;
    logic             qneg_q;
    logic             rneg_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] remd_q;

    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;

    logic             sgn;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div0;
    logic             ovf;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .div_mag (dmag_q),
        .rem_out (rem_d),
        .quo_out (quo_d)
    );

    // Unrecognised funct3 values fall through as unsigned division.
    assign sgn   = is_signed_op(funct3);
    assign a_neg = sgn & dividend[WIDTH-1];
    assign b_neg = sgn & divisor[WIDTH-1];
    assign a_mag = a_neg ? -dividend : dividend;
    assign b_mag = b_neg ? -divisor : divisor;
    assign div0  = (divisor == '0);
    assign ovf   = sgn && (dividend == INT_MIN) && (divisor == ALL_ONES);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= DIV_IDLE;
            count_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dmag_q  <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            remd_q  <= '0;
        end else if (flush) begin
            state_q <= DIV_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                DIV_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (div0) begin
                            quot_q  <= ALL_ONES;
                            remd_q  <= dividend;
                            done_q  <= 1'b1;
                            state_q <= DIV_DONE;
                        end else if (ovf) begin
                            quot_q  <= INT_MIN;
                            remd_q  <= '0;
                            done_q  <= 1'b1;
                            state_q <= DIV_DONE;
                        end else begin
                            rem_q   <= '0;
                            quo_q   <= a_mag;
                            dmag_q  <= b_mag;
                            qneg_q  <= a_neg ^ b_neg;
                            rneg_q  <= a_neg;
                            count_q <= '0;
                            state_q <= DIV_CALC;
                        end
                    end
                end
                DIV_CALC: begin
                    rem_q   <= rem_d;
                    quo_q   <= quo_d;
                    count_q <= count_q + 1'b1;
                    if (count_q == CW'(WIDTH-1)) begin
                        state_q <= DIV_FIX;
                    end
                end
                DIV_FIX: begin
                    quot_q  <= qneg_q ? -quo_q : quo_q;
                    remd_q  <= rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                    done_q  <= 1'b1;
                    state_q <= DIV_DONE;
                end
                DIV_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = remd_q;

endmodule
